ibex_ascon_state_file: RTL
==========================

// Module: ibex_ascon_state_file
// PURPOSE
//  Architectural holder of the 320-bit ASCON state that the EX-stage ASCON-p round logic consumes
//  and updates. Presents the full state to EX every cycle, commits the updated state EX returns on
//  update_done, and gives the core a 32-bit word port for loading/storing state from/to GPRs.
//  Tracks permutation instructions in flight to block word accesses and count completed updates.
// PARAMETERS
//  WordAccessEn  1   1: word port functional; 0: word_gnt_o tied 0, word path removed
//  CommitCntW    16  width of commit_cnt_o, 1..32
// PORTS
//  clk_i                  in   1          clock
//  rst_ni                 in   1          synchronous reset, active low
//  rdata_ascon_o          out  320        current state (ascon_state_t) to EX
//  wdata_ascon_i          in   320        updated state (ascon_state_t) from EX
//  ascon_instruction_ex_i in   1          ASCON permutation instruction present in EX
//  ascon_update_done_i    in   1          EX result in wdata_ascon_i is final this cycle
//  clear_i                in   1          zero whole state
//  word_req_i             in   1          word access request, held until granted
//  word_we_i              in   1          1 write, 0 read
//  word_addr_i            in   4          word index 0..9
//  word_wdata_i           in   32         write data
//  word_gnt_o             out  1          request accepted this cycle
//  word_rvalid_o          out  1          response valid (one cycle after grant)
//  word_rdata_o           out  32         read data, valid with word_rvalid_o
//  word_err_o             out  1          response is an error, valid with word_rvalid_o
//  busy_o                 out  1          permutation in flight
//  perm_abort_o           out  1          pulse: in-flight permutation left EX without done
//  commit_cnt_o           out  CommitCntW number of EX commits, wraps
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): state=0, FSM=IDLE, word_rvalid_o/word_err_o/word_rdata_o=0,
//    perm_abort_o=0, commit_cnt_o=0. Reset mid-permutation discards it; no commit, no abort pulse.
//  - rdata_ascon_o = state register, no combinational path from wdata_ascon_i.
//  - Word map: word a -> lane a>>1 (64-bit lane), a[0]=0 bits [31:0], a[0]=1 bits [63:32].
//  - FSM IDLE/PERM:
//    IDLE: instr&done -> commit, stay IDLE; instr&~done -> PERM.
//    PERM: done -> commit (done only honoured while instr=1), -> IDLE; ~instr&~done -> IDLE,
//          perm_abort_o=1 next cycle, state unchanged.
//  - Commit: state <= wdata_ascon_i, commit_cnt_o += 1 (mod 2^CommitCntW), both at same edge.
//  - busy_o = (FSM==PERM) | ascon_instruction_ex_i (combinational).
//  - word_gnt_o = WordAccessEn & word_req_i & ~busy_o. Ungranted request stalls; no side effect.
//  - Granted access: next cycle word_rvalid_o=1 for exactly one cycle. Read: word_rdata_o = word
//    value before any same-edge update. Write: word updated at grant edge; word_rdata_o=0.
//  - word_addr_i >= 10: granted, no write, word_rvalid_o=1 with word_err_o=1, word_rdata_o=0.
//  - Priority at one edge: reset > clear_i > commit > word write. clear_i during PERM zeroes state
//    and FSM stays PERM; a later commit overwrites. Word write coincident with clear_i is dropped
//    but still granted and acknowledged (err=0). Commit and word grant never coincide (busy_o).
//  - Back-to-back granted accesses allowed every cycle; responses in order, one per cycle.
// STRUCTURE
//  - ibex_ascon_defines: ascon_state_t (logic [4:0][63:0]), ASCON_NUM_WORDS=10,
//    ascon_sf_state_e {ASCON_SF_IDLE, ASCON_SF_PERM}.
//  - Single module; word select/insert is a small mux, no sub-module. Instantiated next to the
//    EX block; outputs wired to EX's state input, inputs from EX's state output and done flag.
// TESTING
//  - Reset: drive rst_ni=0 one edge with state loaded -> rdata_ascon_o=0, commit_cnt_o=0, busy_o=0.
//  - Word write then read: write addr 3 = 32'hDEADBEEF, read addr 3 -> rdata 32'hDEADBEEF one cycle
//    after grant; rdata_ascon_o lane 1 bits [63:32]=32'hDEADBEEF, other bits 0.
//  - Single-cycle perm: instr=1,done=1,wdata=320'h1 -> state=1 next cycle, commit_cnt_o=1, FSM IDLE.
//  - Multi-cycle perm with stalled read: instr=1 for 3 cycles, done on 3rd, word read addr 0 held
//    throughout -> gnt=0 for 3 cycles, granted cycle 4, returns committed word.
//  - Abort: instr=1,done=0 one cycle then instr=0 -> perm_abort_o pulse 1 cycle, state unchanged,
//    commit_cnt_o unchanged; word_addr_i=12 read -> rvalid=1, err=1, rdata=0.
//  - Collisions: clear_i with word write addr 0 -> state all 0, rvalid=1 err=0; commit_cnt_o at
//    2^CommitCntW-1 plus one commit -> 0.

Source files
------------

// File: rtl/ibex_ascon_defines.sv
// Shared types for the ASCON state file: the 320-bit state viewed as five
// 64-bit lanes, the number of 32-bit words it holds, and the tracking FSM.
package ibex_ascon_defines;

   typedef logic [4:0][63:0] ascon_state_t;

   localparam int unsigned ASCON_NUM_WORDS = 10;

   typedef enum logic {
      ASCON_SF_IDLE,
      ASCON_SF_PERM
   } ascon_sf_state_e;

endpackage

// File: rtl/ibex_ascon_state_file.sv
// Architectural ASCON state holder. EX reads the whole state every cycle and
// hands back the permuted state on update_done; the core loads/stores single
// 32-bit words through the word port while no permutation is in flight.
module ibex_ascon_state_file
   import ibex_ascon_defines::*;
#(
   parameter bit          WordAccessEn = 1'b1,
   parameter int unsigned CommitCntW   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output ascon_state_t          rdata_ascon_o,
   input  ascon_state_t          wdata_ascon_i,
   input  logic                  ascon_instruction_ex_i,
   input  logic                  ascon_update_done_i,
   input  logic                  clear_i,
   input  logic                  word_req_i,
   input  logic                  word_we_i,
   input  logic [3:0]            word_addr_i,
   input  logic [31:0]           word_wdata_i,
   output logic                  word_gnt_o,
   output logic                  word_rvalid_o,
   output logic [31:0]           word_rdata_o,
   output logic                  word_err_o,
   output logic                  busy_o,
   output logic                  perm_abort_o,
   output logic [CommitCntW-1:0] commit_cnt_o
);

   ascon_state_t          state_q, state_d;
   ascon_sf_state_e       fsm_q, fsm_d;
   logic                  abort_d, abort_q;
   logic                  commit;
   logic                  addr_ok;
   logic                  word_wr;
   logic [31:0]           word_rd;
   logic                  rvalid_q, err_q;
   logic [31:0]           rdata_q;
   logic [CommitCntW-1:0] commit_cnt_q;

   // EX's result is only trusted while its instruction is still present.
   assign commit  = ascon_instruction_ex_i & ascon_update_done_i;
   assign busy_o  = (fsm_q == ASCON_SF_PERM) | ascon_instruction_ex_i;
   assign addr_ok = (word_addr_i < 4'(ASCON_NUM_WORDS));

   assign word_gnt_o = WordAccessEn & word_req_i & ~busy_o;
   assign word_wr    = word_gnt_o & word_we_i & addr_ok;

   // Permutation tracking: leave PERM on a commit, or abort if EX drops the instruction.
   always_comb begin
      fsm_d   = fsm_q;
      abort_d = 1'b0;
      unique case (fsm_q)
         ASCON_SF_IDLE: begin
            if (ascon_instruction_ex_i && !ascon_update_done_i) begin
               fsm_d = ASCON_SF_PERM;
            end
         end
         ASCON_SF_PERM: begin
            if (commit) begin
               fsm_d = ASCON_SF_IDLE;
            end else if (!ascon_instruction_ex_i) begin
               fsm_d   = ASCON_SF_IDLE;
               abort_d = 1'b1;
            end
         end
         default: fsm_d = ASCON_SF_IDLE;
      endcase
   end

   // Select the addressed 32-bit word (word a lives in lane a>>1, half a[0]).
   always_comb begin
      word_rd = '0;
      for (int i = 0; i < ASCON_NUM_WORDS; i++) begin
         if (word_addr_i == 4'(i)) begin
            word_rd = state_q[i/2][(i%2)*32 +: 32];
         end
      end
   end

   // Next state with priority clear > commit > word write.
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = '0;
      end else if (commit) begin
         state_d = wdata_ascon_i;
      end else if (word_wr) begin
         for (int i = 0; i < ASCON_NUM_WORDS; i++) begin
            if (word_addr_i == 4'(i)) begin
               state_d[i/2][(i%2)*32 +: 32] = word_wdata_i;
            end
         end
      end
   end

   // State, FSM and commit counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= '0;
         fsm_q        <= ASCON_SF_IDLE;
         abort_q      <= 1'b0;
         commit_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         fsm_q   <= fsm_d;
         abort_q <= abort_d;
         if (commit) begin
            commit_cnt_q <= commit_cnt_q + CommitCntW'(1);
         end
      end
   end

   // One-cycle response for each granted word access; data only for valid reads.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= word_gnt_o;
         err_q    <= word_gnt_o & ~addr_ok;
         rdata_q  <= (word_gnt_o & ~word_we_i & addr_ok) ? word_rd : 32'h0;
      end
   end

   assign rdata_ascon_o = state_q;
   assign word_rvalid_o = rvalid_q;
   assign word_err_o    = err_q;
   assign word_rdata_o  = rdata_q;
   assign perm_abort_o  = abort_q;
   assign commit_cnt_o  = commit_cnt_q;

endmodule
